// File: rtl/dircc_processing_mem_port2_arbiter.sv
// Round-robin arbiter with bounded hold sharing the 16-bit s2 memory port between RX writer (req0) and TX reader (req1).
// Define DIRCC_P2ARB_STATS_EN to add per-requester saturating stall counters with a synchronous clear.
module dircc_processing_mem_port2_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   req0_address,
    input  logic                req0_read,
    input  logic                req0_write,
    input  logic [DATA_W-1:0]   req0_writedata,
    input  logic [DATA_W/8-1:0] req0_byteenable,
    output logic                req0_waitrequest,
    output logic [DATA_W-1:0]   req0_readdata,
    output logic                req0_readdatavalid,
    input  logic [ADDR_W-1:0]   req1_address,
    input  logic                req1_read,
    input  logic                req1_write,
    input  logic [DATA_W-1:0]   req1_writedata,
    input  logic [DATA_W/8-1:0] req1_byteenable,
    output logic                req1_waitrequest,
    output logic [DATA_W-1:0]   req1_readdata,
    output logic                req1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic [DATA_W/8-1:0] mem_byteenable,
    input  logic [DATA_W-1:0]   mem_readdata
`ifdef DIRCC_P2ARB_STATS_EN
    ,
    input  logic                stats_clear,
    output logic [31:0]         stall0_cnt,
    output logic [31:0]         stall1_cnt
`endif
);

    localparam logic [3:0] HOLD_LIM = 4'(MAX_HOLD - 1);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic       active0;
    logic       active1;
    logic       grant0;
    logic       grant1;
    logic       accept;
    logic       winner;
    logic       last_owner;
    logic       owner_vld;
    logic [3:0] hold_cnt;
    logic       rdv_pend;
    logic       rdv_id;

    assign active0 = req0_read | req0_write;
    assign active1 = req1_read | req1_write;
    assign accept  = grant0 | grant1;

    // Until the first transfer after reset there is no owner to hold for, so requester 0 wins contention.
    always_comb begin
        winner = 1'b0;
        if (owner_vld) begin
            winner = (hold_cnt < HOLD_LIM) ? last_owner : ~last_owner;
        end
    end

    // Grants are suppressed while reset is high so the memory sees an idle port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (active0 && !active1) begin
                grant0 = 1'b1;
            end else if (active1 && !active0) begin
                grant1 = 1'b1;
            end else if (active0 && active1) begin
                grant0 = ~winner;
                grant1 = winner;
            end
        end
    end

    always_comb begin
        mem_chipselect = accept;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        if (grant0) begin
            mem_write      = req0_write;
            mem_address    = req0_address;
            mem_writedata  = req0_writedata;
            mem_byteenable = req0_byteenable;
        end else if (grant1) begin
            mem_write      = req1_write;
            mem_address    = req1_address;
            mem_writedata  = req1_writedata;
            mem_byteenable = req1_byteenable;
        end
    end

    assign req0_waitrequest   = active0 & ~grant0;
    assign req1_waitrequest   = active1 & ~grant1;
    assign req0_readdata      = mem_readdata;
    assign req1_readdata      = mem_readdata;
    assign req0_readdatavalid = rdv_pend & ~rdv_id;
    assign req1_readdatavalid = rdv_pend & rdv_id;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
            owner_vld  <= 1'b0;
            hold_cnt   <= 4'd0;
            rdv_pend   <= 1'b0;
            rdv_id     <= 1'b0;
        end else begin
            rdv_pend <= accept & ~mem_write;
            if (accept) begin
                owner_vld <= 1'b1;
                if (owner_vld && (grant1 == last_owner)) begin
                    hold_cnt <= sat_inc4(hold_cnt);
                end else begin
                    hold_cnt   <= 4'd0;
                    last_owner <= grant1;
                end
                if (!mem_write) begin
                    rdv_id <= grant1;
                end
            end
        end
    end

`ifdef DIRCC_P2ARB_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall0_cnt <= 32'd0;
            stall1_cnt <= 32'd0;
        end else if (stats_clear) begin
            stall0_cnt <= 32'd0;
            stall1_cnt <= 32'd0;
        end else begin
            if (req0_waitrequest) begin
                stall0_cnt <= sat_inc32(stall0_cnt);
            end
            if (req1_waitrequest) begin
                stall1_cnt <= sat_inc32(stall1_cnt);
            end
        end
    end
`endif

endmodule
